// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port unified memory between the instruction-fetch port
// (if_*) and the data-access port (d_*) of the pipelined MIPS CPU. Accesses
// are serialised through a four-state FSM (IDLE -> ISSUE -> WAIT -> DONE) and
// the memory is driven with a fixed-latency protocol.
//
// Handshake: a requester raises *_req with stable address/data and holds it
// until its *_ready is sampled high. *_ready is a one-cycle pulse presented in
// the DONE state. The requester may drop or change *_req only on that edge.
//
// Parameters
//   MEM_LATENCY  cycles from the mem_en cycle to the cycle in which mem_rdata
//                is valid (>= 1)
//
// Ports
//   clk, reset               rising-edge clock, synchronous active-high reset
//   if_req/if_addr           fetch request and word address
//   if_rdata/if_ready        fetched instruction (held) and completion pulse
//   d_req/d_we/d_addr/       data request, write enable, address, write data,
//   d_wdata/d_be             byte enables
//   d_rdata/d_ready          data read result (held) and completion pulse
//   mem_en/mem_we/mem_addr/  registered memory strobe, write strobe, address,
//   mem_wdata/mem_be         write data and byte enables (valid in ISSUE only)
//   mem_rdata                memory read data
//   busy                     high in every state except IDLE
//   state_o                  current FSM state (debug)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          grant_q;       // 0 = fetch, 1 = data
    logic          last_grant_q;  // port served by the previous grant
    logic          we_q;          // granted access is a write
    logic          mem_en_q;
    logic          mem_we_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [3:0]    mem_be_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   d_rdata_q;
    logic          if_ready_q;
    logic          d_ready_q;
    logic          busy_q;

    // Data wins when it is the only requester, or on a tie when fetch was
    // served last. last_grant resets to fetch, so data wins the first tie.
    logic grant_d;
    assign grant_d = d_req & (~if_req | ~last_grant_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b0;
            we_q         <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (if_req || d_req) begin
                        state_q      <= ISSUE;
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        we_q         <= grant_d & d_we;
                        mem_en_q     <= 1'b1;
                        mem_we_q     <= grant_d & d_we;
                        mem_addr_q   <= grant_d ? d_addr  : if_addr;
                        mem_wdata_q  <= grant_d ? d_wdata : 32'h0;
                        mem_be_q     <= grant_d ? d_be    : 4'b1111;
                        busy_q       <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Memory-side outputs are only meaningful in ISSUE.
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    mem_be_q    <= '0;
                    cnt_q       <= CNT_INIT;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        // Last WAIT cycle: mem_rdata is valid now.
                        if (!we_q) begin
                            if (grant_q) begin
                                d_rdata_q <= mem_rdata;
                            end else begin
                                if_rdata_q <= mem_rdata;
                            end
                        end
                        if_ready_q <= ~grant_q;
                        d_ready_q  <= grant_q;
                        state_q    <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    if_ready_q <= 1'b0;
                    d_ready_q  <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign busy      = busy_q;
    assign state_o   = state_q;

endmodule
